// File: rtl/cla_rr_arbiter.sv
// Round-robin arbiter sharing one cla_8bit adder among NUM_REQ requesters, with a one-deep
// tagged response register. Define CLA_ARB_STATS_EN to add per-requester grant counters.
module cla_rr_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = $clog2(NUM_REQ)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NUM_REQ-1:0]   req_valid,
   output logic [NUM_REQ-1:0]   req_ready,
   input  logic [NUM_REQ*8-1:0] req_a,
   input  logic [NUM_REQ*8-1:0] req_b,
   output logic [7:0]           adder_a,
   output logic [7:0]           adder_b,
   input  logic [8:0]           adder_sum,
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic [ID_W-1:0]      rsp_id,
   output logic [8:0]           rsp_sum
`ifdef CLA_ARB_STATS_EN
   ,
   input  logic [ID_W-1:0]      stat_sel,
   input  logic                 stat_clr,
   output logic [15:0]          stat_count
`endif
);

   logic            rsp_valid_q, rsp_valid_d;
   logic [ID_W-1:0] rsp_id_q, rsp_id_d;
   logic [8:0]      rsp_sum_q, rsp_sum_d;
   logic [ID_W-1:0] ptr_q, ptr_d;

   logic            can_accept;
   logic            gnt_found;
   logic [ID_W-1:0] gnt_idx;
   logic            transfer;
   logic [ID_W:0]   scan_sum;
   logic [ID_W-1:0] scan_idx;
   logic [7:0]      op_a [NUM_REQ];
   logic [7:0]      op_b [NUM_REQ];

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_ops
      assign op_a[g] = req_a[8*g +: 8];
      assign op_b[g] = req_b[8*g +: 8];
   end

   assign can_accept = !rsp_valid_q || rsp_ready;

   // Scan upward from ptr with wrap-around; the first valid index wins.
   always_comb begin
      gnt_found = 1'b0;
      gnt_idx   = '0;
      scan_sum  = '0;
      scan_idx  = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         scan_sum = {1'b0, ptr_q} + (ID_W+1)'(i);
         if (scan_sum >= (ID_W+1)'(NUM_REQ)) begin
            scan_sum = scan_sum - (ID_W+1)'(NUM_REQ);
         end
         scan_idx = scan_sum[ID_W-1:0];
         if (!gnt_found && req_valid[scan_idx]) begin
            gnt_found = 1'b1;
            gnt_idx   = scan_idx;
         end
      end
   end

   // Requests are ignored while reset is held so nothing is granted before release.
   assign transfer = gnt_found && can_accept && rst_n;

   always_comb begin
      req_ready = '0;
      if (transfer) begin
         req_ready[gnt_idx] = 1'b1;
      end
   end

   always_comb begin
      adder_a = 8'h00;
      adder_b = 8'h00;
      if (gnt_found) begin
         adder_a = op_a[gnt_idx];
         adder_b = op_b[gnt_idx];
      end
   end

   always_comb begin
      rsp_valid_d = rsp_valid_q;
      rsp_id_d    = rsp_id_q;
      rsp_sum_d   = rsp_sum_q;
      ptr_d       = ptr_q;
      if (transfer) begin
         rsp_valid_d = 1'b1;
         rsp_id_d    = gnt_idx;
         rsp_sum_d   = adder_sum;
         ptr_d       = (gnt_idx == ID_W'(NUM_REQ-1)) ? '0 : gnt_idx + 1'b1;
      end else if (rsp_ready) begin
         rsp_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_valid_q <= 1'b0;
         rsp_id_q    <= '0;
         rsp_sum_q   <= '0;
         ptr_q       <= '0;
      end else begin
         rsp_valid_q <= rsp_valid_d;
         rsp_id_q    <= rsp_id_d;
         rsp_sum_q   <= rsp_sum_d;
         ptr_q       <= ptr_d;
      end
   end

   assign rsp_valid = rsp_valid_q;
   assign rsp_id    = rsp_id_q;
   assign rsp_sum   = rsp_sum_q;

`ifdef CLA_ARB_STATS_EN
   logic [15:0] stat_cnt_q [NUM_REQ];
   logic [15:0] stat_cnt_d [NUM_REQ];

   // Saturating grant counters; a clear overrides a same-cycle increment.
   always_comb begin
      for (int i = 0; i < NUM_REQ; i++) begin
         stat_cnt_d[i] = stat_cnt_q[i];
         if (stat_clr) begin
            stat_cnt_d[i] = 16'h0000;
         end else if (transfer && (gnt_idx == ID_W'(i)) && (stat_cnt_q[i] != 16'hFFFF)) begin
            stat_cnt_d[i] = stat_cnt_q[i] + 16'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            stat_cnt_q[i] <= 16'h0000;
         end
      end else begin
         for (int i = 0; i < NUM_REQ; i++) begin
            stat_cnt_q[i] <= stat_cnt_d[i];
         end
      end
   end

   assign stat_count = ({1'b0, stat_sel} < (ID_W+1)'(NUM_REQ)) ? stat_cnt_q[stat_sel] : 16'h0000;
`endif

endmodule

// File: tb/tb_cla_rr_arbiter.sv
// Self-checking bench for cla_rr_arbiter: directed vector table, hand-written corner sequences
// and randomized traffic checked against a behavioural model.
module tb_cla_rr_arbiter;

   localparam int N   = 4;
   localparam int IDW = 2;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [N-1:0]  req_valid = '0;
   logic [N-1:0]  req_ready;
   logic [N*8-1:0] req_a = '0;
   logic [N*8-1:0] req_b = '0;
   logic [7:0]    adder_a;
   logic [7:0]    adder_b;
   logic [8:0]    adder_sum;
   logic          rsp_valid;
   logic          rsp_ready = 1'b0;
   logic [IDW-1:0] rsp_id;
   logic [8:0]    rsp_sum;
`ifdef CLA_ARB_STATS_EN
   logic [IDW-1:0] stat_sel = '0;
   logic          stat_clr = 1'b0;
   logic [15:0]   stat_count;
`endif

   int errCount   = 0;
   int checkCount = 0;

   cla_rr_arbiter #(.NUM_REQ(N)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
      .adder_a   (adder_a),
      .adder_b   (adder_b),
      .adder_sum (adder_sum),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_id    (rsp_id),
      .rsp_sum   (rsp_sum)
`ifdef CLA_ARB_STATS_EN
      ,
      .stat_sel  (stat_sel),
      .stat_clr  (stat_clr),
      .stat_count(stat_count)
`endif
   );

   always #5 clk = ~clk;

   // Stand-in for the shared cla_8bit: sign-extended 9-bit sum, carry-in 0.
   assign adder_sum = {adder_a[7], adder_a} + {adder_b[7], adder_b};

   typedef struct {
      logic [3:0]  valid;
      logic [31:0] a;
      logic [31:0] b;
      logic        rdy;
      logic [3:0]  expReady;
      logic        expValid;
      logic [1:0]  expId;
      logic [8:0]  expSum;
   } vec_t;

   vec_t vecs [13];

   localparam logic [31:0] OPA = 32'h80FF7F05;
   localparam logic [31:0] OPB = 32'hFF010103;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checkCount++;
      if (actual !== expected) begin
         errCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic [3:0] v, input logic [31:0] a, input logic [31:0] b, input logic rdy);
      @(negedge clk);
      req_valid = v;
      req_a     = a;
      req_b     = b;
      rsp_ready = rdy;
      #1;
   endtask

   task automatic stepClock;
      @(posedge clk);
      #1;
   endtask

   task automatic checkRsp(input string tag, input logic v, input logic [1:0] id, input logic [8:0] sum);
      checkOutput({tag, " rsp_valid"}, 32'(rsp_valid), 32'(v));
      checkOutput({tag, " rsp_id"}, 32'(rsp_id), 32'(id));
      checkOutput({tag, " rsp_sum"}, 32'(rsp_sum), 32'(sum));
   endtask

   // Behavioural model state
   int         mPtr;
   logic       mValid;
   int         mId;
   logic [8:0] mSum;

   initial begin
      #5000000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      errCount++;
      $display("Result: errors=%0d of %0d checks", errCount, checkCount + 1);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      vecs[0]  = '{4'b0100, 32'h007F0000, 32'h00010000, 1'b1, 4'b0100, 1'b1, 2'd2, 9'h080};
      vecs[1]  = '{4'b0100, 32'h00800000, 32'h00800000, 1'b1, 4'b0100, 1'b1, 2'd2, 9'h100};
      vecs[2]  = '{4'b0100, 32'h00FF0000, 32'h00010000, 1'b1, 4'b0100, 1'b1, 2'd2, 9'h000};
      vecs[3]  = '{4'b0000, 32'h00000000, 32'h00000000, 1'b1, 4'b0000, 1'b0, 2'd2, 9'h000};
      vecs[4]  = '{4'b1001, OPA, OPB, 1'b1, 4'b1000, 1'b1, 2'd3, 9'h17F};
      vecs[5]  = '{4'b1001, OPA, OPB, 1'b1, 4'b0001, 1'b1, 2'd0, 9'h008};
      vecs[6]  = '{4'b1001, OPA, OPB, 1'b1, 4'b1000, 1'b1, 2'd3, 9'h17F};
      vecs[7]  = '{4'b1111, OPA, OPB, 1'b0, 4'b0000, 1'b1, 2'd3, 9'h17F};
      vecs[8]  = '{4'b1111, OPA, OPB, 1'b1, 4'b0001, 1'b1, 2'd0, 9'h008};
      vecs[9]  = '{4'b1111, OPA, OPB, 1'b1, 4'b0010, 1'b1, 2'd1, 9'h080};
      vecs[10] = '{4'b1111, OPA, OPB, 1'b1, 4'b0100, 1'b1, 2'd2, 9'h000};
      vecs[11] = '{4'b1111, OPA, OPB, 1'b1, 4'b1000, 1'b1, 2'd3, 9'h17F};
      vecs[12] = '{4'b1111, OPA, OPB, 1'b1, 4'b0001, 1'b1, 2'd0, 9'h008};

      // Reset state, with all requesters valid to show nothing is granted under reset
      applyStimulus(4'hF, OPA, OPB, 1'b1);
      checkOutput("reset req_ready", 32'(req_ready), 32'h0);
      stepClock();
      checkRsp("reset", 1'b0, 2'd0, 9'h000);
      @(negedge clk);
      rst_n     = 1'b1;
      req_valid = '0;

      for (int i = 0; i < 13; i++) begin
         applyStimulus(vecs[i].valid, vecs[i].a, vecs[i].b, vecs[i].rdy);
         checkOutput($sformatf("vec%0d req_ready", i), 32'(req_ready), 32'(vecs[i].expReady));
         stepClock();
         checkRsp($sformatf("vec%0d", i), vecs[i].expValid, vecs[i].expId, vecs[i].expSum);
      end

      // Back-pressure: result for id0 pending, consumer stalls 3 cycles
      for (int i = 0; i < 3; i++) begin
         applyStimulus(4'hF, OPA, OPB, 1'b0);
         checkOutput($sformatf("stall%0d req_ready", i), 32'(req_ready), 32'h0);
         stepClock();
         checkRsp($sformatf("stall%0d", i), 1'b1, 2'd0, 9'h008);
      end
      applyStimulus(4'hF, OPA, OPB, 1'b1);
      checkOutput("release req_ready", 32'(req_ready), 32'b0010);
      stepClock();
      checkRsp("release", 1'b1, 2'd1, 9'h080);

      // Reset mid-operation clears the pending response immediately
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      checkRsp("midreset", 1'b0, 2'd0, 9'h000);
      checkOutput("midreset req_ready", 32'(req_ready), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      checkOutput("postreset req_ready", 32'(req_ready), 32'b0001);
      stepClock();
      checkRsp("postreset", 1'b1, 2'd0, 9'h008);

      // Randomized traffic against the model
      @(negedge clk);
      rst_n     = 1'b0;
      req_valid = '0;
      @(negedge clk);
      rst_n  = 1'b1;
      mPtr   = 0;
      mValid = 1'b0;
      mId    = 0;
      mSum   = 9'h000;
      for (int n = 0; n < 1500; n++) begin
         logic [3:0]  v;
         logic [31:0] a;
         logic [31:0] b;
         logic        rdy;
         logic        canAcc;
         int          best;
         int          bestDist;
         int          sa;
         int          sb;
         logic [7:0]  ba;
         logic [7:0]  bb;
         v   = 4'($urandom);
         a   = $urandom;
         b   = $urandom;
         rdy = ($urandom_range(0, 3) != 0);
         applyStimulus(v, a, b, rdy);

         canAcc   = !mValid || rdy;
         best     = -1;
         bestDist = N;
         for (int i = 0; i < N; i++) begin
            if (v[i] && (((i - mPtr + N) % N) < bestDist)) begin
               bestDist = (i - mPtr + N) % N;
               best     = i;
            end
         end

         if (best >= 0 && canAcc) begin
            ba = 8'(a >> (8 * best));
            bb = 8'(b >> (8 * best));
            checkOutput("rand req_ready", 32'(req_ready), 32'(1) << best);
            checkOutput("rand adder_a", 32'(adder_a), 32'(ba));
            checkOutput("rand adder_b", 32'(adder_b), 32'(bb));
         end else begin
            ba = 8'h00;
            bb = 8'h00;
            checkOutput("rand req_ready idle", 32'(req_ready), 32'h0);
         end
         if (v == 4'h0) begin
            checkOutput("rand adder idle", {16'h0, adder_a, adder_b}, 32'h0);
         end

         stepClock();
         if (best >= 0 && canAcc) begin
            sa     = $signed(ba);
            sb     = $signed(bb);
            mSum   = 9'(sa + sb);
            mId    = best;
            mValid = 1'b1;
            mPtr   = (best + 1) % N;
         end else if (rdy) begin
            mValid = 1'b0;
         end
         checkRsp("rand", mValid, 2'(mId), mSum);
      end

`ifdef CLA_ARB_STATS_EN
      @(negedge clk);
      req_valid = '0;
      stat_clr  = 1'b1;
      stepClock();
      @(negedge clk);
      stat_clr = 1'b0;
      stat_sel = 2'd1;
      #1;
      checkOutput("stat clr1", 32'(stat_count), 32'h0);
      applyStimulus(4'b0010, OPA, OPB, 1'b1);
      repeat (5) stepClock();
      applyStimulus(4'b0000, OPA, OPB, 1'b1);
      checkOutput("stat five", 32'(stat_count), 32'd5);
      applyStimulus(4'b0001, OPA, OPB, 1'b1);
      stat_sel = 2'd0;
      repeat (65535) stepClock();
      checkOutput("stat full", 32'(stat_count), 32'hFFFF);
      stepClock();
      checkOutput("stat saturate", 32'(stat_count), 32'hFFFF);
      @(negedge clk);
      stat_clr = 1'b1;
      stepClock();
      @(negedge clk);
      stat_clr  = 1'b0;
      req_valid = '0;
      #1;
      checkOutput("stat clr0", 32'(stat_count), 32'h0);
      stat_sel = 2'd1;
      #1;
      checkOutput("stat clr1b", 32'(stat_count), 32'h0);
`endif

      $display("Result: errors=%0d of %0d checks", errCount, checkCount);
      $finish;
   end

endmodule

// File: doc/cla_rr_arbiter.md
# cla_rr_arbiter

Round-robin arbiter and result stage that shares one combinational `cla_8bit` adder among `NUM_REQ` requesters. Each cycle it grants at most one requester and drives the granted operands onto the shared adder. It captures the 9-bit sign-extended sum into a one-deep response register, tagged with the requester ID. It sits between the requesting datapath clients and the single adder instance, which the parent instantiates and wires to the `adder_*` ports.

## Interface
- `NUM_REQ`, default 4: number of requesters, 2..8.
- `ID_W`, default `$clog2(NUM_REQ)`: width of requester ID; derived, do not override.
- `clk`  in  1: rising-edge clock.
- `rst_n`  in  1: asynchronous, active-low reset.
- `req_valid`  in  NUM_REQ: per-requester operand-valid.
- `req_ready`  out  NUM_REQ: per-requester grant/accept; at most one bit high.
- `req_a`  in  NUM_REQ*8: operand A for requester i is bits [8i+7:8i], signed.
- `req_b`  in  NUM_REQ*8: operand B for requester i is bits [8i+7:8i], signed.
- `adder_a`  out  8: to the shared adder's A input.
- `adder_b`  out  8: to the shared adder's B input.
- `adder_sum`  in  9: from the shared adder's Sum output. Sign-extended two's-complement; carry-in is fixed at 0.
- `rsp_valid`  out  1: response holds a result.
- `rsp_ready`  in  1: consumer accepts the response.
- `rsp_id`  out  ID_W: index of the requester that produced `rsp_sum`.
- `rsp_sum`  out  9: captured sum.

## Operation
- **Stage free:** `can_accept = !rsp_valid || rsp_ready`.
- **Arbitration:** round-robin over `req_valid`. Search starts at `ptr` and wraps from `NUM_REQ-1` to 0. The first valid index found is `gnt`.
- **Handshake:** `req_ready[gnt] = can_accept`; all other `req_ready` bits are 0. A transfer occurs when `req_valid[i] && req_ready[i]`.
- **Adder drive on transfer:** `adder_a = req_a[gnt]` and `adder_b = req_b[gnt]`, combinationally.
- **Adder drive with no requester valid:** `adder_a = adder_b = 0`. `adder_*` is don't-care for checking when `can_accept` is 0, but must be stable with the inputs.
- **On a transfer clock edge:**
  - `rsp_sum <= adder_sum`
  - `rsp_id <= gnt`
  - `rsp_valid <= 1`
  - `ptr <= (gnt+1) mod NUM_REQ`
- **Response stall:** if `rsp_valid && !rsp_ready`, then `rsp_sum`, `rsp_id` and `rsp_valid` hold, and no `req_ready` is asserted. `ptr` holds.
- **Simultaneous drain and accept:** when `rsp_ready` is 1 and a transfer occurs in the same cycle, the new result replaces the old one and `rsp_valid` stays 1.
- **Drain without a new transfer:** `rsp_valid <= 0`. `rsp_sum` and `rsp_id` hold their last values.
- **Arithmetic:** no overflow is possible; the range is -256..+254. Required results:
  - 0x7F + 0x01 = 9'h080
  - 0x80 + 0x80 = 9'h100
  - 0xFF + 0x01 = 9'h000
- **Request hold rule:** a requester holds `req_valid` and its operands stable until accepted. The arbiter does not check this rule.

## Timing
- **Reset values:** while `rst_n` is low, `rsp_valid=0`, `rsp_id=0`, `rsp_sum=0`, `ptr=0`. `req_ready` is all 0 because `rsp_valid=0` and no request is considered until reset is released; `adder_a/b` follow the combinational rule.
- **Reset mid-operation:** any pending response is discarded immediately (asynchronous clear). The first grant after release starts the search at index 0.
- **Latency:** a request accepted at edge N gives `rsp_valid=1` after edge N with the matching sum. That is 1 cycle from acceptance.
- **Throughput:** 1 result/cycle while `rsp_ready` is held high.
- **Fairness:** with all requesters valid continuously, grants go 0,1,2,…,NUM_REQ-1,0,…. No requester waits more than NUM_REQ-1 grants.
- **Paths:** `req_ready` depends combinationally on `req_valid` and `rsp_ready`. The `adder_*` path is req → adder → register, a single cycle.

## Configuration
- **Macro:** `CLA_ARB_STATS_EN`.
- **When defined:**
  - Adds ports `stat_sel  in  ID_W`, `stat_clr  in  1` and `stat_count  out  16`.
  - Keeps one 16-bit grant counter per requester. A counter increments on each transfer of its requester and saturates at 16'hFFFF.
  - Counters reset to 0 on `rst_n` low. `stat_clr=1` synchronously clears all counters; clear wins over a same-cycle increment.
  - `stat_count` = counter[`stat_sel`], combinational.
- **When undefined:** the ports and counters are absent; arbitration behaviour is identical.

## Test plan
- **Reset:** assert `rst_n`=0 mid-stream with `rsp_valid`=1 → `rsp_valid`=0, `rsp_id`=0 and `rsp_sum`=0 immediately. The first post-reset grant goes to requester 0 when all requesters are valid.
- **Single requester:** requester 2 only, A=0x7F, B=0x01, `rsp_ready`=1 → next cycle `rsp_valid`=1, `rsp_id`=2, `rsp_sum`=9'h080. Repeat with A=B=0x80 → 9'h100.
- **Fairness:** all 4 requesters valid continuously, `rsp_ready`=1 → `rsp_id` sequence 0,1,2,3,0,1 on consecutive cycles. Exactly one `req_ready` is high each cycle.
- **Back-pressure:** hold `rsp_ready`=0 for 3 cycles with a result pending → `rsp_sum` and `rsp_id` stable, and `req_ready` all 0. Release → the new grant is accepted in the same cycle and the next result replaces the old one with no bubble.
- **Wrap and skip:** valid = {1,0,0,1} (requesters 3 and 0), last grant was 3 → next grant 0, then 3. Requesters 1 and 2 are never granted.
- **Statistics (`CLA_ARB_STATS_EN`):** 5 grants to requester 1 → `stat_sel`=1 gives `stat_count`=5. Preload requester 0's count to 16'hFFFF, then grant requester 0 once more → stays 16'hFFFF. Pulse `stat_clr` → all counts 0.
